// File: rtl/line_delay_buffer_pkg.sv
// line_delay_buffer_pkg: shared FSM state encoding and default sizing constants
//   DEF_DATA_W   - default pixel width in bits
//   DEF_LINE_MAX - default maximum pixels per line (line RAM depth)
//   DEF_ADDR_W   - default column address width (2**DEF_ADDR_W >= DEF_LINE_MAX)
package line_delay_buffer_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_LINE_MAX = 640;
    localparam int DEF_ADDR_W   = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/line_delay_buffer_if.sv
// line_delay_buffer_if: pixel stream bundle between a video source and line_delay_buffer
//   i_sof      - start of frame, marks column 0 of a new frame
//   i_line_len - pixels per line, sampled with i_sof
//   i_valid    - i_data carries a pixel this cycle
//   i_data     - current-line pixel
//   o_valid    - o_data carries a delayed pixel
//   o_data     - pixel from the previous line, same column
//   o_primed   - a full line of this frame is stored
//   modports: master (pixel source / testbench), slave (line_delay_buffer)
interface line_delay_buffer_if
    import line_delay_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              i_sof;
    logic [ADDR_W-1:0] i_line_len;
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_primed;

    modport master (
        output i_sof, i_line_len, i_valid, i_data,
        input  o_valid, o_data, o_primed
    );

    modport slave (
        input  i_sof, i_line_len, i_valid, i_data,
        output o_valid, o_data, o_primed
    );

endinterface

// File: rtl/line_ram.sv
// line_ram: simple dual-port line store, read-first with a 1-cycle registered read
//   clk     - clock
//   i_we    - write enable
//   i_waddr - write column
//   i_wdata - write pixel
//   i_re    - read enable
//   i_raddr - read column
//   o_rdata - registered read pixel (old contents when raddr == waddr)
module line_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read and write share the edge; the non-blocking read returns the
    // pre-write contents, which is what the line delay needs.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_delay_buffer.sv
// line_delay_buffer: delays a pixel stream by exactly one video line
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - line_delay_buffer_if.slave (sof, line_len, valid/data in; valid/data/primed out)
//   Build option: LINE_DELAY_ZERO_FILL_EN - emit a zero for every first-line pixel
//   so the output is 1:1 with the input; otherwise the first line is silent.
module line_delay_buffer
    import line_delay_buffer_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LINE_MAX = DEF_LINE_MAX,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input logic             clk,
    input logic             rst,
    line_delay_buffer_if.slave bus
);

    // Length is one bit wider than a column so LINE_MAX == 2**ADDR_W still fits.
    localparam logic [ADDR_W:0] W_MAX = (ADDR_W+1)'(LINE_MAX);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] w_col_next;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_len;
    logic [ADDR_W:0]   w_len_in;
    logic              w_acc;
    logic              w_last;
    logic              w_stream_acc;
    logic              r_out_valid;
    logic              r_pass;
    logic              r_primed;
    logic              w_valid_next;
    logic              w_pass_next;
    logic              w_primed_next;
    logic [DATA_W-1:0] w_rdata;

    assign w_len_in = {1'b0, bus.i_line_len};
    // Length in force this cycle: a sof applies its clamped length immediately
    // so a pixel arriving with sof already wraps against the new line.
    assign w_len = bus.i_sof
        ? ((bus.i_line_len == '0 || w_len_in > W_MAX) ? W_MAX : w_len_in)
        : r_len;
    assign w_acc        = bus.i_valid && (bus.i_sof || r_state != S_IDLE);
    assign w_waddr      = bus.i_sof ? '0 : r_col;
    assign w_last       = {1'b0, w_waddr} == w_len - (ADDR_W+1)'(1);
    // Only a STREAM pixel that is not restarting the frame has a valid
    // previous-line pixel behind it.
    assign w_stream_acc = w_acc && !bus.i_sof && r_state == S_STREAM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_len       <= W_MAX;
            r_out_valid <= 1'b0;
            r_pass      <= 1'b0;
            r_primed    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_col       <= w_col_next;
            r_len       <= w_len;
            r_out_valid <= w_valid_next;
            r_pass      <= w_pass_next;
            r_primed    <= w_primed_next;
        end
    end

    // A sof always restarts the fill, discarding any partial line; the line
    // completes on the pixel written to the last column.
    always_comb begin
        w_next     = (w_acc && w_last && (bus.i_sof || r_state == S_FILL)) ? S_STREAM
                   : bus.i_sof ? S_FILL
                   : r_state;
        w_col_next = !w_acc ? (bus.i_sof ? '0 : r_col)
                   : w_last ? '0
                   : w_waddr + ADDR_W'(1);
    end

    always_comb begin
        w_pass_next   = w_stream_acc;
`ifdef LINE_DELAY_ZERO_FILL_EN
        w_valid_next  = w_acc;
`else
        w_valid_next  = w_stream_acc;
`endif
        w_primed_next = w_next == S_STREAM;
    end

    line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (LINE_MAX),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_acc),
        .i_waddr (w_waddr),
        .i_wdata (bus.i_data),
        .i_re    (w_acc),
        .i_raddr (w_waddr),
        .o_rdata (w_rdata)
    );

    // RAM read data is passed only for real previous-line pixels, so first-line
    // (zero-fill) outputs and the reset value both read as zero.
    assign bus.o_valid  = r_out_valid;
    assign bus.o_data   = r_pass ? w_rdata : '0;
    assign bus.o_primed = r_primed;

endmodule
